// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, qualifies lock, then frees domain resets staggered.
// Optional retry limit with FAIL state is built when PLL_SEQ_RETRY_LIMIT_EN is defined.
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int STAGGER      = 8,
  parameter int MAX_RETRY    = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic [3:0] dom_rst_n,
  output logic       clk_ready,
  output logic [7:0] relock_cnt,
  output logic       fail
);

  // Release phase ends one cycle after bit 3 frees at count 3*STAGGER.
  localparam int REL_LEN = 3 * STAGGER + 1;
  localparam int MAX_AB  = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int MAX_CD  = (LOCK_TIMEOUT > REL_LEN) ? LOCK_TIMEOUT : REL_LEN;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] REL_LAST     = CNT_W'(REL_LEN);

  localparam logic [2:0] S_RESET   = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_STABLE  = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
  localparam logic [2:0] S_FAIL    = 3'd5;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
`endif

  if (SYNC_STAGES < 2 || MAX_RETRY < 1) begin : g_param_check
    $error("pll_lock_sequencer: SYNC_STAGES must be >= 2 and MAX_RETRY >= 1");
  end

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [SYNC_STAGES-1:0] sync;
  logic                   lk;
  logic [2:0]             state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [3:0]             dom_d;
  logic [7:0]             relock_d;
  logic                   pll_rst_d;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
  logic [RETRY_W-1:0]     retry_cnt, retry_d;
`endif

  // Lock synchronizer: the only reader of pll_locked
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], pll_locked};
  end
  assign lk = sync[SYNC_STAGES-1];

  always_comb begin
    state_d  = state;
    cnt_d    = cnt + 1'b1;
    dom_d    = dom_rst_n;
    relock_d = relock_cnt;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    retry_d  = retry_cnt;
`endif
    case (state)
      S_RESET: begin
        dom_d = '0;
        if (cnt == RST_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        dom_d = '0;
        // A lock seen in the timeout cycle wins over the retry.
        if (lk) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_d   = '0;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
          retry_d = retry_cnt + 1'b1;
          state_d = (retry_cnt == RETRY_LAST) ? S_FAIL : S_RESET;
`else
          state_d = S_RESET;
`endif
        end
      end
      S_STABLE: begin
        dom_d = '0;
        if (!lk) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end
      end
      S_RELEASE: begin
        if (!lk) begin
          state_d = S_RESET;
          cnt_d   = '0;
          dom_d   = '0;
        end else begin
          for (int k = 0; k < 4; k++) dom_d[k] = (cnt >= CNT_W'(k * STAGGER));
          if (cnt == REL_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
            retry_d = '0;
`endif
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt;
        dom_d = '1;
        if (!lk) begin
          state_d  = S_RESET;
          cnt_d    = '0;
          dom_d    = '0;
          relock_d = sat_inc(relock_cnt);
        end
      end
`ifdef PLL_SEQ_RETRY_LIMIT_EN
      S_FAIL: begin
        cnt_d = cnt;
        dom_d = '0;
      end
`endif
      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
        dom_d   = '0;
      end
    endcase

    // A forced relock coinciding with lock loss in RUN counts once.
    if (force_relock) begin
      state_d = S_RESET;
      cnt_d   = '0;
      dom_d   = '0;
      if (state == S_RUN) relock_d = sat_inc(relock_cnt);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
      retry_d = '0;
`endif
    end

    pll_rst_d = (state_d == S_RESET);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    pll_rst_d = pll_rst_d | (state_d == S_FAIL);
`endif
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RESET;
      cnt        <= '0;
      pll_rst    <= 1'b1;
      dom_rst_n  <= '0;
      clk_ready  <= 1'b0;
      relock_cnt <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      pll_rst    <= pll_rst_d;
      dom_rst_n  <= dom_d;
      clk_ready  <= (state_d == S_RUN);
      relock_cnt <= relock_d;
    end
  end

`ifdef PLL_SEQ_RETRY_LIMIT_EN
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
      fail      <= 1'b0;
    end else begin
      retry_cnt <= retry_d;
      fail      <= (state_d == S_FAIL);
    end
  end
`else
  assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: vector table for bring-up/lock loss plus hand sequences.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 32;
  localparam int STAGGER      = 2;
  localparam int MAX_RETRY    = 3;
  localparam int SYNC_STAGES  = 2;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
  localparam logic LIMIT = 1'b1;
`else
  localparam logic LIMIT = 1'b0;
`endif

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic [3:0] dom_rst_n;
  logic       clk_ready;
  logic [7:0] relock_cnt;
  logic       fail;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  pll_lock_sequencer #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_STABLE (LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .STAGGER     (STAGGER),
    .MAX_RETRY   (MAX_RETRY),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .force_relock(force_relock),
    .pll_rst     (pll_rst),
    .dom_rst_n   (dom_rst_n),
    .clk_ready   (clk_ready),
    .relock_cnt  (relock_cnt),
    .fail        (fail)
  );

  always #5 refclk = ~refclk;

  initial begin
    #60000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string      name;
    logic       pr;
    logic [3:0] dom;
    logic       rd;
    logic [7:0] rc;
    logic       f;
  } exp_t;

  typedef struct {
    int         cyc;
    logic       locked;
    logic       pr;
    logic [3:0] dom;
    logic       rd;
    logic [7:0] rc;
  } vec_t;

  exp_t sb[$];
  vec_t tbl [0:21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic pr, input logic [3:0] dom,
                            input logic rd, input logic [7:0] rc, input logic f);
    exp_t e;
    e.name = name; e.pr = pr; e.dom = dom; e.rd = rd; e.rc = rc; e.f = f;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.name, ".pll_rst"},    32'(pll_rst),    32'(e.pr));
      chk({e.name, ".dom_rst_n"},  32'(dom_rst_n),  32'(e.dom));
      chk({e.name, ".clk_ready"},  32'(clk_ready),  32'(e.rd));
      chk({e.name, ".relock_cnt"}, 32'(relock_cnt), 32'(e.rc));
      chk({e.name, ".fail"},       32'(fail),       32'(e.f));
    end
  endtask

  task automatic exp_chk(input string name, input logic pr, input logic [3:0] dom,
                         input logic rd, input logic [7:0] rc, input logic f);
    expect_out($sformatf("%s@%0d", name, cyc), pr, dom, rd, rc, f);
    compare_out();
  endtask

  // Cycle n is observed at the falling edge after n rising edges since release.
  task automatic adv_to(input int c);
    while (cyc < c) begin
      @(posedge refclk);
      @(negedge refclk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    @(negedge refclk);
    rst_n = 1'b0; pll_locked = 1'b0; force_relock = 1'b0;
    #1;
    exp_chk("reset", 1'b1, 4'h0, 1'b0, 8'd0, 1'b0);
    @(negedge refclk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    rst_n = 1'b0; pll_locked = 1'b0; force_relock = 1'b0;

    tbl[0]  = '{0,  1'b0, 1'b1, 4'h0, 1'b0, 8'd0};
    tbl[1]  = '{3,  1'b0, 1'b1, 4'h0, 1'b0, 8'd0};
    tbl[2]  = '{4,  1'b0, 1'b0, 4'h0, 1'b0, 8'd0};
    tbl[3]  = '{10, 1'b1, 1'b0, 4'h0, 1'b0, 8'd0};
    tbl[4]  = '{21, 1'b1, 1'b0, 4'h0, 1'b0, 8'd0};
    tbl[5]  = '{22, 1'b1, 1'b0, 4'h1, 1'b0, 8'd0};
    tbl[6]  = '{23, 1'b1, 1'b0, 4'h1, 1'b0, 8'd0};
    tbl[7]  = '{24, 1'b1, 1'b0, 4'h3, 1'b0, 8'd0};
    tbl[8]  = '{26, 1'b1, 1'b0, 4'h7, 1'b0, 8'd0};
    tbl[9]  = '{27, 1'b1, 1'b0, 4'h7, 1'b0, 8'd0};
    tbl[10] = '{28, 1'b1, 1'b0, 4'hF, 1'b0, 8'd0};
    tbl[11] = '{29, 1'b1, 1'b0, 4'hF, 1'b1, 8'd0};
    tbl[12] = '{40, 1'b0, 1'b0, 4'hF, 1'b1, 8'd0};
    tbl[13] = '{42, 1'b0, 1'b0, 4'hF, 1'b1, 8'd0};
    tbl[14] = '{43, 1'b0, 1'b1, 4'h0, 1'b0, 8'd1};
    tbl[15] = '{46, 1'b0, 1'b1, 4'h0, 1'b0, 8'd1};
    tbl[16] = '{47, 1'b0, 1'b0, 4'h0, 1'b0, 8'd1};
    tbl[17] = '{50, 1'b1, 1'b0, 4'h0, 1'b0, 8'd1};
    tbl[18] = '{61, 1'b1, 1'b0, 4'h0, 1'b0, 8'd1};
    tbl[19] = '{62, 1'b1, 1'b0, 4'h1, 1'b0, 8'd1};
    tbl[20] = '{68, 1'b1, 1'b0, 4'hF, 1'b0, 8'd1};
    tbl[21] = '{69, 1'b1, 1'b0, 4'hF, 1'b1, 8'd1};

    // Nominal bring-up, lock loss in RUN, and full re-sequence
    do_reset();
    for (int i = 0; i < 22; i++) begin
      adv_to(tbl[i].cyc);
      expect_out($sformatf("nom@%0d", tbl[i].cyc), tbl[i].pr, tbl[i].dom, tbl[i].rd, tbl[i].rc, 1'b0);
      compare_out();
      pll_locked = tbl[i].locked;
    end

    // Lock glitch in STABLE delays ready by six cycles
    do_reset();
    adv_to(10); pll_locked = 1'b1;
    adv_to(15); pll_locked = 1'b0;
    adv_to(16); pll_locked = 1'b1;
    adv_to(27); exp_chk("glitch", 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
    adv_to(28); exp_chk("glitch", 1'b0, 4'h1, 1'b0, 8'd0, 1'b0);
    adv_to(29); exp_chk("glitch", 1'b0, 4'h1, 1'b0, 8'd0, 1'b0);
    adv_to(34); exp_chk("glitch", 1'b0, 4'hF, 1'b0, 8'd0, 1'b0);
    adv_to(35); exp_chk("glitch", 1'b0, 4'hF, 1'b1, 8'd0, 1'b0);

    // Lock never arrives: timeout retries
    do_reset();
    adv_to(35);  exp_chk("tmo", 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
    adv_to(36);  exp_chk("tmo", 1'b1, 4'h0, 1'b0, 8'd0, 1'b0);
    adv_to(39);  exp_chk("tmo", 1'b1, 4'h0, 1'b0, 8'd0, 1'b0);
    adv_to(40);  exp_chk("tmo", 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
    adv_to(71);  exp_chk("tmo", 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
    adv_to(72);  exp_chk("tmo", 1'b1, 4'h0, 1'b0, 8'd0, 1'b0);
    adv_to(75);  exp_chk("tmo", 1'b1, 4'h0, 1'b0, 8'd0, 1'b0);
    adv_to(76);  exp_chk("tmo", 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
    adv_to(107); exp_chk("tmo", 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
    adv_to(108); exp_chk("tmo", 1'b1, 4'h0, 1'b0, 8'd0, LIMIT);
    adv_to(112); exp_chk("tmo", LIMIT, 4'h0, 1'b0, 8'd0, LIMIT);
    adv_to(115); exp_chk("tmo", LIMIT, 4'h0, 1'b0, 8'd0, LIMIT);

    // Forced relock out of FAIL (or WAIT_LOCK) with lock present
    force_relock = 1'b1; pll_locked = 1'b1;
    adv_to(116); force_relock = 1'b0;
    exp_chk("frc", 1'b1, 4'h0, 1'b0, 8'd0, 1'b0);
    adv_to(119); exp_chk("frc", 1'b1, 4'h0, 1'b0, 8'd0, 1'b0);
    adv_to(120); exp_chk("frc", 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
    adv_to(136); exp_chk("frc", 1'b0, 4'hF, 1'b0, 8'd0, 1'b0);
    adv_to(137); exp_chk("frc", 1'b0, 4'hF, 1'b1, 8'd0, 1'b0);

    // Forced relock from RUN counts one relock
    adv_to(140); exp_chk("frun", 1'b0, 4'hF, 1'b1, 8'd0, 1'b0);
    force_relock = 1'b1;
    adv_to(141); force_relock = 1'b0;
    exp_chk("frun", 1'b1, 4'h0, 1'b0, 8'd1, 1'b0);
    adv_to(145); exp_chk("frun", 1'b0, 4'h0, 1'b0, 8'd1, 1'b0);
    adv_to(161); exp_chk("frun", 1'b0, 4'hF, 1'b0, 8'd1, 1'b0);
    adv_to(162); exp_chk("frun", 1'b0, 4'hF, 1'b1, 8'd1, 1'b0);

    // Lock loss and force in the same RUN cycle: single increment
    adv_to(170); pll_locked = 1'b0;
    adv_to(172); exp_chk("both", 1'b0, 4'hF, 1'b1, 8'd1, 1'b0);
    force_relock = 1'b1;
    adv_to(173); force_relock = 1'b0;
    exp_chk("both", 1'b1, 4'h0, 1'b0, 8'd2, 1'b0);
    adv_to(180); exp_chk("both", 1'b0, 4'h0, 1'b0, 8'd2, 1'b0);

    // Asynchronous reset during RELEASE after bit 1 freed
    do_reset();
    adv_to(10); pll_locked = 1'b1;
    adv_to(25); exp_chk("arst", 1'b0, 4'h3, 1'b0, 8'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    exp_chk("arst_now", 1'b1, 4'h0, 1'b0, 8'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
